// File: rtl/time_pkg.sv
// time_pkg: shared FSM state type, BCD limits and digit helper for time_keeper.
package time_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEC,
    S_MIN,
    S_HOUR,
    S_SET,
    S_COMMIT
  } tk_state_t;

  localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
  localparam logic [7:0] BCD_HR24_MAX = 8'h23;
  localparam logic [7:0] BCD_HR12_MAX = 8'h12;
  localparam logic [7:0] BCD_HR12_MIN = 8'h01;

  // True when a nibble is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: combinational 2-digit BCD increment. Reaching WRAP_FROM wraps
// to WRAP_TO and raises carry; otherwise the value steps by one decimal unit.
module bcd2_counter #(
  parameter logic [7:0] WRAP_FROM = 8'h59,
  parameter logic [7:0] WRAP_TO   = 8'h00
) (
  input  logic [7:0] value,
  output logic [7:0] value_next,
  output logic       carry
);

  // Low digit rolls into the high digit at 9; wrap point overrides both.
  always_comb begin
    carry      = (value == WRAP_FROM);
    value_next = value;
    if (carry) begin
      value_next = WRAP_TO;
    end else if (value[3:0] >= 4'd9) begin
      value_next = {value[7:4] + 4'd1, 4'd0};
    end else begin
      value_next = {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: counts BCD hh:mm:ss from rising edges of the 1 Hz tick level,
// publishes the time coherently with one-cycle sec/day pulses, and accepts
// validated loads over a valid/ready port.
// Build option: define TIME_KEEPER_12H_EN for 12 h mode with a PM flag;
// left undefined the keeper runs in 24 h mode and pm is tied low.
module time_keeper
  import time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clk_1Hz,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       set_pm,
  output logic       set_err,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick
);

`ifdef TIME_KEEPER_12H_EN
  localparam logic [7:0] HOUR_RST     = BCD_HR12_MAX;
  localparam logic [7:0] HR_WRAP_FROM = BCD_HR12_MAX;
  localparam logic [7:0] HR_WRAP_TO   = BCD_HR12_MIN;
`else
  localparam logic [7:0] HOUR_RST     = 8'h00;
  localparam logic [7:0] HR_WRAP_FROM = BCD_HR24_MAX;
  localparam logic [7:0] HR_WRAP_TO   = 8'h00;
`endif

  localparam logic [7:0] PCNT_LAST = 8'(TICKS_PER_SEC - 1);

  tk_state_t  state_reg;
  logic       c1_reg;
  logic [7:0] pcnt_reg;
  logic       pending_reg;
  logic       loading_reg;
  logic       day_reg;
  logic [7:0] w_hour_reg, w_min_reg, w_sec_reg;
  logic [7:0] cap_hour_reg, cap_min_reg, cap_sec_reg;
`ifdef TIME_KEEPER_12H_EN
  logic       w_pm_reg;
  logic       cap_pm_reg;
`endif

  logic       tick_edge;
  logic       wrap_edge;
  logic       load_ok;
  logic       pcnt_clear;
  logic [7:0] sec_next, min_next, hr_next;
  logic       sec_carry, min_carry, hr_carry;
  logic [23:0] cap_all;
  logic [5:0]  digit_ok;
  logic        range_ok;

  assign tick_edge  = clk_1Hz & ~c1_reg & run;
  assign wrap_edge  = tick_edge & (pcnt_reg == PCNT_LAST);
  assign set_ready  = (state_reg == S_IDLE) & ~pending_reg & ~tick_edge;
  assign pcnt_clear = (state_reg == S_SET) & load_ok;

  bcd2_counter #(.WRAP_FROM(BCD_SEC_MAX), .WRAP_TO(8'h00)) u_sec_cnt (
    .value      (w_sec_reg),
    .value_next (sec_next),
    .carry      (sec_carry)
  );

  bcd2_counter #(.WRAP_FROM(BCD_SEC_MAX), .WRAP_TO(8'h00)) u_min_cnt (
    .value      (w_min_reg),
    .value_next (min_next),
    .carry      (min_carry)
  );

  bcd2_counter #(.WRAP_FROM(HR_WRAP_FROM), .WRAP_TO(HR_WRAP_TO)) u_hr_cnt (
    .value      (w_hour_reg),
    .value_next (hr_next),
    .carry      (hr_carry)
  );

  // Every nibble of the captured load must be a decimal digit.
  assign cap_all = {cap_hour_reg, cap_min_reg, cap_sec_reg};
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_ok[gi] = bcd_digit_ok(cap_all[gi*4 +: 4]);
    end
  endgenerate

`ifdef TIME_KEEPER_12H_EN
  assign range_ok = (cap_sec_reg <= BCD_SEC_MAX) && (cap_min_reg <= BCD_SEC_MAX) &&
                    (cap_hour_reg >= BCD_HR12_MIN) && (cap_hour_reg <= BCD_HR12_MAX);
  logic unused_hr_carry;
  assign unused_hr_carry = hr_carry;
`else
  assign range_ok = (cap_sec_reg <= BCD_SEC_MAX) && (cap_min_reg <= BCD_SEC_MAX) &&
                    (cap_hour_reg <= BCD_HR24_MAX);
  logic unused_set_pm;
  assign unused_set_pm = set_pm;
  assign pm = 1'b0;
`endif

  assign load_ok = (&digit_ok) & range_ok;

  // Tick sampling and prescaler; c1 keeps sampling while run is low so no
  // stale edge appears when counting resumes.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      c1_reg   <= 1'b0;
      pcnt_reg <= 8'd0;
    end else begin
      c1_reg <= clk_1Hz;
      if (pcnt_clear) begin
        pcnt_reg <= 8'd0;
      end else if (tick_edge) begin
        pcnt_reg <= (pcnt_reg == PCNT_LAST) ? 8'd0 : pcnt_reg + 8'd1;
      end
    end
  end

  // Control FSM: ripples a second through the working registers, validates
  // loads, and commits the whole time to the outputs in a single cycle.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      pending_reg  <= 1'b0;
      loading_reg  <= 1'b0;
      day_reg      <= 1'b0;
      w_hour_reg   <= HOUR_RST;
      w_min_reg    <= 8'h00;
      w_sec_reg    <= 8'h00;
      cap_hour_reg <= 8'h00;
      cap_min_reg  <= 8'h00;
      cap_sec_reg  <= 8'h00;
      hour         <= HOUR_RST;
      min          <= 8'h00;
      sec          <= 8'h00;
      sec_tick     <= 1'b0;
      day_tick     <= 1'b0;
      set_err      <= 1'b0;
`ifdef TIME_KEEPER_12H_EN
      w_pm_reg     <= 1'b0;
      cap_pm_reg   <= 1'b0;
      pm           <= 1'b0;
`endif
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;

      // A second that arrives while busy is remembered once; extras are lost.
      if (wrap_edge && (state_reg != S_IDLE)) begin
        pending_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (wrap_edge || pending_reg) begin
            pending_reg <= 1'b0;
            loading_reg <= 1'b0;
            day_reg     <= 1'b0;
            state_reg   <= S_SEC;
          end else if (set_valid && set_ready) begin
            cap_hour_reg <= set_hour;
            cap_min_reg  <= set_min;
            cap_sec_reg  <= set_sec;
`ifdef TIME_KEEPER_12H_EN
            cap_pm_reg   <= set_pm;
`endif
            state_reg    <= S_SET;
          end
        end
        S_SEC: begin
          w_sec_reg <= sec_next;
          state_reg <= sec_carry ? S_MIN : S_COMMIT;
        end
        S_MIN: begin
          w_min_reg <= min_next;
          state_reg <= min_carry ? S_HOUR : S_COMMIT;
        end
        S_HOUR: begin
          w_hour_reg <= hr_next;
`ifdef TIME_KEEPER_12H_EN
          // 11 -> 12 flips AM/PM; only the PM -> AM flip starts a new day.
          if (w_hour_reg == 8'h11) begin
            w_pm_reg <= ~w_pm_reg;
            day_reg  <= w_pm_reg;
          end
`else
          day_reg <= hr_carry;
`endif
          state_reg <= S_COMMIT;
        end
        S_SET: begin
          if (load_ok) begin
            w_hour_reg  <= cap_hour_reg;
            w_min_reg   <= cap_min_reg;
            w_sec_reg   <= cap_sec_reg;
`ifdef TIME_KEEPER_12H_EN
            w_pm_reg    <= cap_pm_reg;
`endif
            loading_reg <= 1'b1;
            state_reg   <= S_COMMIT;
          end else begin
            set_err   <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_COMMIT: begin
          hour     <= w_hour_reg;
          min      <= w_min_reg;
          sec      <= w_sec_reg;
`ifdef TIME_KEEPER_12H_EN
          pm       <= w_pm_reg;
`endif
          sec_tick <= ~loading_reg;
          day_tick <= day_reg & ~loading_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Timekeeping stage downstream of the 1 Hz timer: samples the timer's `clk_1Hz` level as data in the 100 MHz domain. It turns each rising edge into one second of BCD hh:mm:ss time and publishes coherent time fields plus one-cycle second and day pulses. The day pulse feeds the calendar stage. A valid/ready load port lets the UI set the time, and it rejects out-of-range values.

## Interface
- `TICKS_PER_SEC`, default 1: rising edges of `clk_1Hz` per second increment; range 1..255. Simulation uses values >1 with a fast tick.
- `clk_100MHz`  in  1  system clock, 100 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `clk_1Hz`  in  1  tick level from the 1 Hz timer, synchronous to `clk_100MHz`
- `run`  in  1  1 = count seconds; 0 = ignore tick edges
- `set_valid`  in  1  load request
- `set_ready`  out  1  load accepted when high together with `set_valid`
- `set_hour`  in  8  BCD hour to load
- `set_min`  in  8  BCD minute to load
- `set_sec`  in  8  BCD second to load
- `set_pm`  in  1  PM flag for a load; only used in 12 h mode
- `set_err`  out  1  one-cycle pulse when a load is rejected
- `hour`  out  8  BCD hour
- `min`  out  8  BCD minute
- `sec`  out  8  BCD second
- `pm`  out  1  PM flag; constant 0 in 24 h mode
- `sec_tick`  out  1  one-cycle pulse per committed second
- `day_tick`  out  1  one-cycle pulse on day rollover

## Operation
- Edge detect:
  - `c1` is a register holding `clk_1Hz`.
  - `edge = clk_1Hz & ~c1 & run`.
- Prescaler `pcnt` (8 b):
  - On each edge it counts 0..TICKS_PER_SEC-1.
  - It advances the time only on the edge where it wraps to 0.
- FSM states: S_IDLE, S_SEC, S_MIN, S_HOUR, S_SET, S_COMMIT.
- Tick sequence (working registers `w_hour`, `w_min`, `w_sec`):
  - S_IDLE: a wrapping edge, or a set `pending` flag, moves to S_SEC and clears `pending`.
  - S_SEC: `w_sec` increments, 0x59 → 0x00. On carry go to S_MIN, else S_COMMIT.
  - S_MIN: same as S_SEC, on `w_min`. On carry go to S_HOUR, else S_COMMIT.
  - S_HOUR: 24 h mode wraps 0x23 → 0x00. Then S_COMMIT.
  - S_COMMIT: copies the working registers to the outputs in one cycle and pulses `sec_tick`. It also pulses `day_tick` if the hour wrapped. Then S_IDLE.
- A wrapping edge that arrives outside S_IDLE sets `pending`. A further edge while `pending` is already set is dropped.
- Set handshake:
  - `set_ready = (state==S_IDLE) & ~pending & ~edge`. A tick beats a simultaneous set.
  - On transfer, the FSM captures the set fields and goes to S_SET.
  - S_SET checks the load:
    - every BCD digit ≤ 9;
    - `set_sec` ≤ 0x59 and `set_min` ≤ 0x59;
    - `set_hour` ≤ 0x23 in 24 h mode.
  - Load valid: the working registers load, `pcnt` clears to 0, and the FSM goes to S_COMMIT. In this case `sec_tick` and `day_tick` are suppressed.
  - Load invalid: `set_err` pulses, the time is unchanged, and the FSM returns to S_IDLE.
- `run` = 0:
  - `pcnt` freezes and edges are ignored.
  - `c1` keeps sampling, so no false edge appears when `run` rises.
  - Loads are still accepted.

## Timing
- Reset values:
  - all outputs 0, except `set_ready`, which is 1 once the reset is released and no edge is present;
  - time 00:00:00, or 12:00:00 with `pm`=0 in 12 h mode;
  - `pcnt` 0, `pending` 0, state S_IDLE.
- Reset mid-sequence aborts it; outputs return to the reset time immediately, because the reset is asynchronous.
- Latency counts from cycle E, where `edge` is high, to the outputs being visible:
  - E+3 with no carry;
  - E+4 with a minute carry;
  - E+5 with an hour carry.
- `sec_tick` and `day_tick` are high in the same cycle that the new outputs first appear.
- `set_err` appears at cycle T+2, where T is the transfer cycle. A valid load is visible at T+3.
- Outputs never show a partially updated time.

## Configuration
- `TIME_KEEPER_12H_EN` defined (12 h mode):
  - Hour range is 0x01..0x12; 0x12 → 0x01.
  - `pm` toggles on 11:59:59 → 12:00:00.
  - `day_tick` fires only on 11:59:59 PM → 12:00:00 AM.
  - A load also requires `set_hour` to be in 0x01..0x12; `pm` loads from `set_pm`.
- Macro undefined (24 h mode):
  - Hour range is 0x00..0x23.
  - `set_pm` is ignored and `pm` is tied to 0.

## Structure
- Shared package `time_pkg` holds:
  - the FSM state enum;
  - the BCD limit constants `BCD_SEC_MAX`=0x59, `BCD_HR24_MAX`=0x23, `BCD_HR12_MAX`=0x12 and `BCD_HR12_MIN`=0x01.
- One sub-module, `bcd2_counter`: a 2-digit BCD increment with parameterised wrap-from and wrap-to values, producing the next value and a carry. It is instantiated for seconds, minutes and hours, and is combinational.

## Test plan
- Reset, then release: outputs read 00:00:00; `sec_tick`, `day_tick` and `set_err` are 0; `set_ready` is 1.
- Load 23:59:58 with `TICKS_PER_SEC`=1, then two edges:
  - 23:59:59 with one `sec_tick`;
  - then 00:00:00 with `sec_tick` and `day_tick` in the same cycle, 5 cycles after the edge.
- Load `set_min`=0x60, then `set_sec`=0x1A: each gives `set_err` pulsed at T+2 and unchanged time.
- `set_valid` held high in the same cycle as an edge: `set_ready` is 0 that cycle; the tick commits first, then the load is accepted and overwrites the time.
- `TICKS_PER_SEC`=3, `run` toggled low after 2 edges and high again: the increment happens only on the 3rd counted edge; edges while `run`=0 have no effect.
- With `TIME_KEEPER_12H_EN`, load 11:59:59 with `set_pm`=1, then one edge: output 12:00:00 with `pm`=0 and a `day_tick` pulse.
